// File: rtl/mem_bus_decoder.sv
// Address decoder and access sequencer from the processor port to N base/mask regions.
// Latency: mapped 2+W cycles from accepted strobe to cpuReady, unmapped 1; requests are only taken in IDLE.
module mem_bus_decoder #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8,
    parameter int N_REGIONS = 4,
    parameter logic [N_REGIONS*ADDR_W-1:0] REGION_BASE = {16'h8000, 16'hE000, 16'h0800, 16'h0000},
    parameter logic [N_REGIONS*ADDR_W-1:0] REGION_MASK = {16'hF000, 16'hE000, 16'hF800, 16'hF800},
    parameter logic [N_REGIONS*4-1:0]      REGION_WAIT = {4'd1, 4'd0, 4'd2, 4'd0},
    parameter logic [DATA_W-1:0]           OPEN_BUS    = 8'hFF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [ADDR_W-1:0]             cpuAddr,
    input  logic                          cpuStrobe,
    input  logic                          cpuWrite,
    input  logic [DATA_W-1:0]             cpuDataWrite,
    output logic [DATA_W-1:0]             cpuDataRead,
    output logic                          cpuReady,
    output logic                          cpuFault,
    output logic [ADDR_W-1:0]             faultAddr,
    output logic [ADDR_W-1:0]             regAddr,
    output logic [DATA_W-1:0]             regDataWrite,
    output logic                          regWrite,
    output logic [N_REGIONS-1:0]          regStrobe,
    input  logic [N_REGIONS*DATA_W-1:0]   regDataRead
);

    localparam int IDX_W = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1;

    typedef enum logic [1:0] {IDLE, STROBE, WAIT, FINISH} state_t;

    state_t             state, stateNext;
    logic               hit;
    logic [IDX_W-1:0]   hitIdx;
    logic [IDX_W-1:0]   idx;
    logic               faulted;
    logic [3:0]         waitCnt;
    logic [3:0]         idxWait;
    logic [DATA_W-1:0]  idxData;

    // Scan from the top so the lowest matching index is the one left standing.
    always_comb begin
        hit    = 1'b0;
        hitIdx = '0;
        for (int i = N_REGIONS - 1; i >= 0; i--) begin
            if ((cpuAddr & REGION_MASK[i*ADDR_W +: ADDR_W]) ==
                (REGION_BASE[i*ADDR_W +: ADDR_W] & REGION_MASK[i*ADDR_W +: ADDR_W])) begin
                hit    = 1'b1;
                hitIdx = IDX_W'(i);
            end
        end
    end

    assign idxWait = REGION_WAIT[idx*4 +: 4];
    assign idxData = regDataRead[idx*DATA_W +: DATA_W];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        regStrobe = '0;
        cpuReady  = 1'b0;
        cpuFault  = 1'b0;
        case (state)
            IDLE: begin
                if (cpuStrobe) begin
                    stateNext = hit ? STROBE : FINISH;
                end
            end
            STROBE: begin
                regStrobe[idx] = 1'b1;
                stateNext      = (idxWait != 4'd0) ? WAIT : FINISH;
            end
            WAIT: begin
                if (waitCnt == 4'd1) begin
                    stateNext = FINISH;
                end
            end
            FINISH: begin
                cpuReady  = 1'b1;
                cpuFault  = faulted;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Read data is captured on the same edge that moves the FSM into FINISH.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cpuDataRead  <= '0;
            faultAddr    <= '0;
            regAddr      <= '0;
            regDataWrite <= '0;
            regWrite     <= 1'b0;
            idx          <= '0;
            faulted      <= 1'b0;
            waitCnt      <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpuStrobe) begin
                        regAddr      <= cpuAddr;
                        regDataWrite <= cpuDataWrite;
                        regWrite     <= cpuWrite;
                        idx          <= hitIdx;
                        faulted      <= !hit;
                        if (!hit) begin
                            faultAddr <= cpuAddr;
                            if (!cpuWrite) begin
                                cpuDataRead <= OPEN_BUS;
                            end
                        end
                    end
                end
                STROBE: begin
                    waitCnt <= idxWait;
                    if (idxWait == 4'd0 && !regWrite) begin
                        cpuDataRead <= idxData;
                    end
                end
                WAIT: begin
                    waitCnt <= waitCnt - 4'd1;
                    if (waitCnt == 4'd1 && !regWrite) begin
                        cpuDataRead <= idxData;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_decoder.sv
// Bench for mem_bus_decoder: directed scenarios with literal expectations, then random traffic
// checked every cycle against a transaction-level model of the region map.
module tb_mem_bus_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpuAddr;
    logic        cpuStrobe;
    logic        cpuWrite;
    logic [7:0]  cpuDataWrite;
    logic [7:0]  cpuDataRead;
    logic        cpuReady;
    logic        cpuFault;
    logic [15:0] faultAddr;
    logic [15:0] regAddr;
    logic [7:0]  regDataWrite;
    logic        regWrite;
    logic [3:0]  regStrobe;
    logic [31:0] regDataRead;

    mem_bus_decoder dut (
        .clk(clk), .reset(reset), .cpuAddr(cpuAddr), .cpuStrobe(cpuStrobe),
        .cpuWrite(cpuWrite), .cpuDataWrite(cpuDataWrite), .cpuDataRead(cpuDataRead),
        .cpuReady(cpuReady), .cpuFault(cpuFault), .faultAddr(faultAddr),
        .regAddr(regAddr), .regDataWrite(regDataWrite), .regWrite(regWrite),
        .regStrobe(regStrobe), .regDataRead(regDataRead)
    );

    always #5 clk = ~clk;

    // Region map written out per region, independent of the packed parameter layout.
    localparam logic [15:0] BASES [4] = '{16'h0000, 16'h0800, 16'hE000, 16'h8000};
    localparam logic [15:0] MASKS [4] = '{16'hF800, 16'hF800, 16'hE000, 16'hF000};
    localparam int          WAITS [4] = '{0, 2, 0, 1};

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic int regionOf(input logic [15:0] a);
        for (int i = 0; i < 4; i++)
            if ((a & MASKS[i]) == (BASES[i] & MASKS[i])) return i;
        return -1;
    endfunction

    // Transaction model: cycle numbers of the strobe and ready pulses of the pending access.
    bit          modelOn = 0;
    int          e = 0;
    int          pendStrobe = -100, pendReady = -100, pendRegion = -1;
    logic [15:0] pendAddr = '0;
    logic        pendWrite = 1'b0;
    logic [7:0]  pendWdata = '0;
    logic [7:0]  expData = '0;
    logic [15:0] expFaultAddr = '0;
    logic        expReady = 1'b0, expFault = 1'b0;
    logic [3:0]  expStrobe = '0;

    always @(posedge clk) begin
        e++;
        if (!reset) begin
            modelOn      = 1;
            pendStrobe   = -100;
            pendReady    = -100;
            expData      = '0;
            expFaultAddr = '0;
        end else begin
            if (cpuStrobe && e >= pendReady + 2) begin
                pendRegion = regionOf(cpuAddr);
                pendAddr   = cpuAddr;
                pendWrite  = cpuWrite;
                pendWdata  = cpuDataWrite;
                if (pendRegion < 0) begin
                    pendStrobe = -100;
                    pendReady  = e;
                end else begin
                    pendStrobe = e;
                    pendReady  = e + 1 + WAITS[pendRegion];
                end
            end
            if (e == pendReady) begin
                if (pendRegion < 0) begin
                    expFaultAddr = pendAddr;
                    if (!pendWrite) expData = 8'hFF;
                end else if (!pendWrite) begin
                    expData = regDataRead[pendRegion*8 +: 8];
                end
            end
        end
        expReady  = (e == pendReady);
        expFault  = expReady && (pendRegion < 0);
        expStrobe = (e == pendStrobe) ? (4'b0001 << pendRegion) : 4'b0000;
    end

    always @(negedge clk) begin
        if (modelOn) begin
            chk("cpuReady", {31'd0, cpuReady}, {31'd0, expReady});
            chk("cpuFault", {31'd0, cpuFault}, {31'd0, expFault});
            chk("regStrobe", {28'd0, regStrobe}, {28'd0, expStrobe});
            chk("cpuDataRead", {24'd0, cpuDataRead}, {24'd0, expData});
            chk("faultAddr", {16'd0, faultAddr}, {16'd0, expFaultAddr});
            if (expStrobe != 4'b0000) begin
                chk("regAddr", {16'd0, regAddr}, {16'd0, pendAddr});
                chk("regWrite", {31'd0, regWrite}, {31'd0, pendWrite});
                chk("regDataWrite", {24'd0, regDataWrite}, {24'd0, pendWdata});
            end
        end
    end

    // Issues one request from a negedge and returns what was seen; ends in IDLE at a negedge.
    task automatic doAccess(input logic [15:0] a, input logic w, input logic [7:0] d, input bit poke,
                            output int lat, output logic [3:0] s1, output logic f, output logic [7:0] rd);
        lat = -1; s1 = '0; f = 1'b0; rd = '0;
        cpuAddr = a; cpuWrite = w; cpuDataWrite = d; cpuStrobe = 1'b1;
        @(negedge clk);
        cpuStrobe = 1'b0;
        s1 = regStrobe;
        for (int n = 1; n <= 40; n++) begin
            if (cpuReady) begin
                lat = n; f = cpuFault; rd = cpuDataRead;
                break;
            end
            cpuStrobe = poke;
            @(negedge clk);
        end
        cpuStrobe = 1'b0;
        @(negedge clk);
    endtask

    int          lat;
    logic [3:0]  s1;
    logic        f;
    logic [7:0]  rd;

    initial begin
        reset = 1'b0; cpuStrobe = 1'b1; cpuAddr = 16'h0123; cpuWrite = 1'b0;
        cpuDataWrite = '0; regDataRead = 32'h3C77C35A;

        chk("model_r0", regionOf(16'h0123), 0);
        chk("model_r1", regionOf(16'h0FFF), 1);
        chk("model_top", regionOf(16'hFFFF), 2);
        chk("model_unmapped", regionOf(16'h4000), 32'hFFFFFFFF);

        repeat (3) @(negedge clk);
        chk("rst_strobe", {28'd0, regStrobe}, 0);
        chk("rst_ready", {31'd0, cpuReady}, 0);
        chk("rst_data", {24'd0, cpuDataRead}, 0);
        chk("rst_faultAddr", {16'd0, faultAddr}, 0);
        reset = 1'b1; cpuStrobe = 1'b0;
        @(negedge clk);

        doAccess(16'h0123, 1'b0, 8'h00, 0, lat, s1, f, rd);
        chk("r0_strobe", {28'd0, s1}, 32'h1);
        chk("r0_lat", lat, 2);
        chk("r0_data", {24'd0, rd}, 32'h5A);

        doAccess(16'h0FFF, 1'b0, 8'h00, 1, lat, s1, f, rd);
        chk("r1_strobe", {28'd0, s1}, 32'h2);
        chk("r1_lat", lat, 4);
        chk("r1_data", {24'd0, rd}, 32'hC3);

        cpuAddr = 16'hE000; cpuWrite = 1'b1; cpuDataWrite = 8'hA5; cpuStrobe = 1'b1;
        @(negedge clk);
        cpuStrobe = 1'b0;
        chk("wr_strobe", {28'd0, regStrobe}, 32'h4);
        chk("wr_regWrite", {31'd0, regWrite}, 1);
        chk("wr_regData", {24'd0, regDataWrite}, 32'hA5);
        chk("wr_regAddr", {16'd0, regAddr}, 32'hE000);
        @(negedge clk);
        chk("wr_ready", {31'd0, cpuReady}, 1);
        chk("wr_keep", {24'd0, cpuDataRead}, 32'hC3);
        @(negedge clk);

        doAccess(16'hFFFF, 1'b0, 8'h00, 0, lat, s1, f, rd);
        chk("top_strobe", {28'd0, s1}, 32'h4);
        chk("top_data", {24'd0, rd}, 32'h77);

        doAccess(16'h4000, 1'b0, 8'h00, 0, lat, s1, f, rd);
        chk("un_lat", lat, 1);
        chk("un_fault", {31'd0, f}, 1);
        chk("un_strobe", {28'd0, s1}, 0);
        chk("un_data", {24'd0, rd}, 32'hFF);
        chk("un_faultAddr", {16'd0, faultAddr}, 32'h4000);

        doAccess(16'h9000, 1'b1, 8'h12, 0, lat, s1, f, rd);
        chk("unw_fault", {31'd0, f}, 1);
        chk("unw_faultAddr", {16'd0, faultAddr}, 32'h9000);
        chk("unw_data", {24'd0, rd}, 32'hFF);

        cpuAddr = 16'h8001; cpuWrite = 1'b0; cpuStrobe = 1'b1;
        @(negedge clk);
        cpuStrobe = 1'b0;
        chk("abort_strobe", {28'd0, regStrobe}, 32'h8);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) chk("abort_noready", {31'd0, cpuReady}, 0);
        repeat (3) begin
            @(negedge clk);
            chk("abort_quiet", {31'd0, cpuReady}, 0);
        end
        chk("abort_data", {24'd0, cpuDataRead}, 0);

        doAccess(16'h0000, 1'b0, 8'h00, 0, lat, s1, f, rd);
        chk("post_lat", lat, 2);
        chk("post_data", {24'd0, rd}, 32'h5A);

        for (int c = 0; c < 1500; c++) begin
            int k;
            k = $urandom_range(0, 3);
            regDataRead  = $urandom;
            reset        = ($urandom_range(0, 149) != 0);
            cpuStrobe    = ($urandom_range(0, 2) == 0);
            cpuWrite     = $urandom_range(0, 1);
            cpuDataWrite = 8'($urandom);
            case ($urandom_range(0, 4))
                0: cpuAddr = 16'($urandom);
                1: cpuAddr = 16'hFFFF;
                2: cpuAddr = ($urandom_range(0, 1) != 0) ? 16'h4000 : 16'h9000;
                default: cpuAddr = BASES[k] | (16'($urandom) & ~MASKS[k]);
            endcase
            @(negedge clk);
        end
        reset = 1'b1; cpuStrobe = 1'b0;
        repeat (8) @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
